// File: rtl/seg7_pkg.sv
// Shared types, digit table and FSM encoding for the seven-segment readback checker.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} glyphs for hex digits 0..F
  localparam seg7_t SEG7_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic [1:0] {
    SETTLE      = 2'd0,
    PRESENT     = 2'd1,
    WAIT_CHANGE = 2'd2
  } state_t;

  function automatic logic [4:0] seg7_add5(input logic [3:0] a, input logic [3:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational seven-segment glyph to nibble decoder; unknown glyphs give nibble 0 and legal 0.
module seg7_decode
  import seg7_pkg::*;
(
  input  seg7_t      i_seg,
  output logic [3:0] o_nibble,
  output logic       o_legal
);

  // Table search over all sixteen legal glyphs
  always_comb begin
    o_nibble = 4'd0;
    o_legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == SEG7_HEX[i]) begin
        o_nibble = 4'(i);
        o_legal  = 1'b1;
      end else begin
        o_nibble = o_nibble;
      end
    end
  end

endmodule

// File: rtl/seg7_readback_checker.sv
// Debounces the HEX0..HEX3 display bus, decodes A, B and the 5-bit sum, and presents each stable snapshot once.
// Defining SEG7_MISMATCH_COUNT_EN adds a saturating mismatch_cnt output.
module seg7_readback_checker
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] hex0_in,
  input  logic [6:0] hex1_in,
  input  logic [6:0] hex2_in,
  input  logic [6:0] hex3_in,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic [4:0] sum,
  output logic [3:0] digit_err,
  output logic       sum_ok
`ifdef SEG7_MISMATCH_COUNT_EN
  ,
  output logic [7:0] mismatch_cnt
`endif
);

  localparam logic [7:0] STABLE_LIM  = 8'(STABLE_CYCLES);
  localparam logic [7:0] STABLE_LAST = 8'(STABLE_CYCLES - 1);

  logic [27:0] w_hex_in;
  logic [27:0] r_hex_q;
  logic [27:0] r_snap;
  logic [7:0]  r_cnt;
  state_t      r_state;
  state_t      w_state_nxt;
  logic        w_same;
  logic        w_latch;
  logic        w_cnt_clr;
  logic        r_out_valid;
  logic [3:0]  r_op_a;
  logic [3:0]  r_op_b;
  logic [4:0]  r_sum;
  logic [3:0]  r_digit_err;
  logic        r_sum_ok;

  logic [3:0]  w_nib [4];
  logic [3:0]  w_legal;
  logic [3:0]  w_err;
  logic [4:0]  w_sum_dec;
  logic        w_ok;

  assign w_hex_in = {hex3_in, hex2_in, hex1_in, hex0_in};
  assign w_same   = (w_hex_in == r_hex_q);

  for (genvar g = 0; g < 4; g++) begin : g_dec
    seg7_decode u_dec (
      .i_seg   (r_hex_q[g*7 +: 7]),
      .o_nibble(w_nib[g]),
      .o_legal (w_legal[g])
    );
  end

  // The carry digit may only show 0 or 1; anything else is flagged even if it is a valid glyph
  assign w_err     = {(~w_legal[3]) | (w_nib[3] > 4'd1), ~w_legal[2:0]};
  assign w_sum_dec = {(w_nib[3] == 4'd1), w_nib[2]};
  assign w_ok      = (w_err == 4'd0) && (seg7_add5(w_nib[0], w_nib[1]) == w_sum_dec);

  // Next-state logic for settle / present / wait-for-change
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    w_cnt_clr   = 1'b0;
    case (r_state)
      SETTLE: begin
        if (w_same && (r_cnt == STABLE_LAST)) begin
          w_latch     = 1'b1;
          w_state_nxt = PRESENT;
        end else begin
          w_state_nxt = SETTLE;
        end
      end
      PRESENT: begin
        if (out_ready) begin
          w_state_nxt = WAIT_CHANGE;
        end else begin
          w_state_nxt = PRESENT;
        end
      end
      WAIT_CHANGE: begin
        if (w_hex_in != r_snap) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = SETTLE;
        end else begin
          w_state_nxt = WAIT_CHANGE;
        end
      end
      default: begin
        w_state_nxt = SETTLE;
      end
    endcase
  end

  // Input capture, stability counter, FSM state and the latched snapshot outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_hex_q     <= {4{SEG7_BLANK}};
      r_snap      <= {4{SEG7_BLANK}};
      r_cnt       <= 8'd0;
      r_state     <= SETTLE;
      r_out_valid <= 1'b0;
      r_op_a      <= 4'd0;
      r_op_b      <= 4'd0;
      r_sum       <= 5'd0;
      r_digit_err <= 4'd0;
      r_sum_ok    <= 1'b0;
    end else begin
      r_hex_q     <= w_hex_in;
      r_state     <= w_state_nxt;
      r_out_valid <= (w_state_nxt == PRESENT);
      if (!w_same || w_cnt_clr) begin
        r_cnt <= 8'd0;
      end else if (r_cnt < STABLE_LIM) begin
        r_cnt <= r_cnt + 8'd1;
      end
      if (w_latch) begin
        r_snap      <= r_hex_q;
        r_op_a      <= w_nib[0];
        r_op_b      <= w_nib[1];
        r_sum       <= w_sum_dec;
        r_digit_err <= w_err;
        r_sum_ok    <= w_ok;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign sum       = r_sum;
  assign digit_err = r_digit_err;
  assign sum_ok    = r_sum_ok;

`ifdef SEG7_MISMATCH_COUNT_EN
  logic [7:0] r_mismatch_cnt;

  // Saturating count of accepted snapshots whose sum check failed
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mismatch_cnt <= 8'd0;
    end else if ((r_state == PRESENT) && out_ready && !r_sum_ok && (r_mismatch_cnt != 8'hFF)) begin
      r_mismatch_cnt <= r_mismatch_cnt + 8'd1;
    end
  end

  assign mismatch_cnt = r_mismatch_cnt;
`endif

endmodule

// File: doc/seg7_readback_checker.md
Name: seg7_readback_checker

Overview:
Receiving end of the four-digit seven-segment display bus (HEX0..HEX3) driven by the tiny calculator.
- Samples the active-low segment patterns and waits until they are stable.
- Decodes each pattern back to a nibble.
- Reconstructs operand A (HEX0), operand B (HEX1) and the 5-bit sum ({HEX3, HEX2}).
- Checks that A + B equals the displayed sum.
- Presents each stable snapshot once over a valid/ready handshake.
- Used as an on-chip self-check and as a bench scoreboard front end.

Parameters:
- STABLE_CYCLES, 4: consecutive unchanged samples required before a snapshot is accepted; legal range 1..255.

Ports:
- clk, input, 1: system clock; all state updates on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- hex0_in, input, 7: active-low segments {g,f,e,d,c,b,a}, operand A digit.
- hex1_in, input, 7: operand B digit.
- hex2_in, input, 7: sum low digit.
- hex3_in, input, 7: sum carry digit; only 0 and 1 are legal.
- out_valid, output, 1: snapshot available.
- out_ready, input, 1: consumer accepts the snapshot.
- op_a, output, 4: decoded HEX0.
- op_b, output, 4: decoded HEX1.
- sum, output, 5: {carry, low digit} decoded from HEX3/HEX2.
- digit_err, output, 4: bit i set means HEXi holds an illegal pattern (HEX3 is illegal if not 0 or 1).
- sum_ok, output, 1: digit_err == 0 and op_a + op_b == sum (5-bit compare).

Behaviour:
- Decode table (active-low gfedcba):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110
  - Any other pattern is illegal: the decoded nibble is 0 and the matching digit_err bit is set.
- Input stage: one register hex_q (28 bits) captures {hex3_in..hex0_in} every cycle.
- Stability counter cnt (8 bits):
  - If the inputs differ from hex_q: cnt <= 0.
  - Else if cnt < STABLE_CYCLES: cnt <= cnt + 1.
- FSM states:
  - SETTLE: if the inputs equal hex_q and cnt == STABLE_CYCLES-1, latch decoded hex_q into the output registers and go to PRESENT.
  - PRESENT: out_valid = 1. Outputs are frozen regardless of input activity. On out_valid && out_ready, go to WAIT_CHANGE.
  - WAIT_CHANGE: out_valid = 0. When the inputs differ from the latched snapshot, cnt <= 0 and go to SETTLE. Identical patterns are never re-presented.
- Latency: out_valid rises on the (STABLE_CYCLES+1)th rising edge after the last input change. A change at any time during SETTLE restarts the count.
- Input change in PRESENT: ignored until the handshake completes. WAIT_CHANGE then compares the live inputs against the snapshot, so the change is still detected.
- out_ready held high: the handshake completes on the first out_valid cycle, giving a single-cycle valid pulse.
- Reset (rst_n = 0 at a rising edge), including mid-operation:
  - state <= SETTLE, cnt <= 0, hex_q <= 7'h7F per digit (all segments off).
  - out_valid = 0, op_a = 0, op_b = 0, sum = 0, digit_err = 0, sum_ok = 0.
- Width rules: op_a + op_b is computed 5 bits wide with no truncation.

Optional Feature:
- SEG7_MISMATCH_COUNT_EN defined:
  - Adds output mismatch_cnt[7:0], a saturating count of completed handshakes with sum_ok = 0.
  - Counter is cleared by reset and holds at 255.
- Undefined: the port and the counter do not exist; all other behaviour is identical.

Decomposition:
- Package seg7_pkg:
  - typedef seg7_t (logic [6:0]).
  - localparam array SEG7_HEX[16] holding the table above.
  - SEG7_BLANK = 7'h7F.
  - FSM enum state_t {SETTLE, PRESENT, WAIT_CHANGE}.
- Sub-module seg7_decode: combinational seg7_t -> {nibble, legal}, instantiated four times.
- The top level holds the input register, counter, FSM and sum checker.

Test Plan:
- Reset, then HEX0..3 = 0110000, 0100100, 0010010, 1000000, out_ready = 1, STABLE_CYCLES = 4 -> out_valid pulses exactly on edge 5 with op_a = 3, op_b = 2, sum = 5, sum_ok = 1, digit_err = 0.
- HEX = E, 1, F, 0 with out_ready = 0 for 10 cycles -> out_valid stays high with frozen outputs op_a = 14, op_b = 1, sum = 15. Raising out_ready gives one handshake, then out_valid = 0 while the inputs are unchanged.
- HEX = 8, 8, 0, 1 -> sum = 16, sum_ok = 1. Then HEX = F, F, E, 1 -> sum = 30, sum_ok = 1. Then HEX = F, F, F, 1 -> sum = 31, sum_ok = 0 (mismatch count = 1 with SEG7_MISMATCH_COUNT_EN).
- HEX0 toggles every 3 cycles -> out_valid never asserts. Inputs then held -> out_valid asserts 5 edges after the last toggle.
- HEX2 = 1111111 and HEX3 = 0100100 -> digit_err = 4'b1100, sum_ok = 0.
- rst_n low for one edge while in PRESENT -> out_valid = 0 and all outputs are zero next cycle. The same stable inputs are then re-presented after 5 edges.
